r4_fft_seq_ctrl: RTL and testbench
==================================

Name: r4_fft_seq_ctrl

Overview:
Front-end sequencer for the radix-4 pipeline FFT chain (bf2_one, bf2_two and twiddle-multiply units). It accepts a job of NBLK transform blocks of length N = 2^ldn and gates the input sample stream. It registers the samples and generates block_sync, stage_sync, data_val and ldn_rg for unit 0. It then counts outputs at the chain tail to report job completion.

Parameters:
MAN_WIDTH, 16, mantissa width of real/imag samples
EXP_WIDTH, 6, block-floating-point exponent width
LDN_MIN, 2, smallest legal log2 transform length
LDN_MAX, 11, largest legal log2 transform length (N = 2048)
DRAIN_TO, 8192, drain timeout in cycles

Ports:
clk_sys  in  1  system clock
rst_sys_n  in  1  asynchronous active-low reset
start_i  in  1  job start pulse; sampled only in IDLE
ldn_i  in  4  log2 N for the job
nblk_i  in  8  number of blocks in the job; 0 is illegal
in_val_i  in  1  input sample valid
in_ready_o  out  1  controller accepts a sample this cycle
in_real_i  in  MAN_WIDTH  input real, signed
in_imag_i  in  MAN_WIDTH  input imag, signed
in_exp_i  in  EXP_WIDTH  input exponent, signed
block_sync_o  out  1  first sample of the job, to unit 0
stage_sync_o  out  1  first sample of each block, to unit 0
data_val_o  out  1  sample valid, to unit 0
data_real_o  out  MAN_WIDTH  registered real
data_imag_o  out  MAN_WIDTH  registered imag
data_exp_o  out  EXP_WIDTH  registered exponent
ldn_rg_o  out  4  latched ldn, held constant for the whole job
tail_val_i  in  1  data_val from the last pipeline unit
busy_o  out  1  state is not IDLE
done_o  out  1  one-cycle pulse on normal completion
err_o  out  2  sticky error code: 01 = illegal config, 10 = drain timeout; cleared by start_i

Behaviour:
- Reset (async): state IDLE. All outputs are 0, including data buses, ldn_rg_o and err_o.
- Acceptance rule: a sample is accepted when in_val_i & in_ready_o.
- Output timing: on each accepted sample, the next cycle drives data_val_o=1 and the registered data. There is exactly 1 cycle latency. data_val_o=0 in every other cycle; data buses hold their last value.
- Sample counters:
  - samp_cnt counts 0..N-1 and wraps.
  - blk_cnt counts 0..nblk-1.
  - stage_sync_o = 1 with the output sample whose samp_cnt was 0.
  - block_sync_o = 1 additionally only when blk_cnt was also 0.
  - Both syncs are always coincident with data_val_o=1.
- State IDLE: in_ready_o=0.
  - start_i with LDN_MIN ≤ ldn_i ≤ LDN_MAX and nblk_i ≠ 0: latch ldn_rg_o and nblk, clear counters and err_o, go to RUN.
  - start_i with any other configuration: set err_o=01 and stay in IDLE.
- State RUN: in_ready_o=1.
  - When the last sample of the last block (samp_cnt=N-1, blk_cnt=nblk-1) is accepted, go to DRAIN. in_ready_o=0 starting the next cycle.
- State DRAIN: in_ready_o=0.
  - out_cnt counts tail_val_i pulses (tail pulses are also counted during RUN).
  - out_cnt = N·nblk: pulse done_o for 1 cycle and go to IDLE.
  - DRAIN_TO cycles elapse in DRAIN first: set err_o=10 and go to IDLE without asserting done_o.
  - out_cnt is 20 bits wide; it must not overflow for N=2048, nblk=255.
- start_i is ignored outside IDLE.
- ldn_rg_o must never change while busy_o=1.
- in_val_i gaps are allowed in RUN: counters hold and syncs stay aligned to accepted samples only.
- Reset mid-job: the controller returns to IDLE immediately and all counters clear. The downstream pipeline is expected to be reset on the same rst_sys_n.

Test Plan:
- Single block: ldn=4, nblk=1, 16 back-to-back samples → data_val_o high 16 cycles starting 1 cycle after first accept; block_sync_o and stage_sync_o on the 1st only; in_ready_o low after the 16th; then 16 tail_val_i pulses → done_o pulses once, busy_o falls.
- Multi-block with gaps: ldn=2, nblk=3, in_val_i toggling 1/0 → stage_sync_o on output samples 0, 4, 8; block_sync_o on sample 0 only; exactly 12 data_val_o pulses.
- Illegal configuration: start_i with ldn=1 → err_o=01 and busy_o stays 0. start_i with ldn=12 → err_o=01. start_i with nblk=0 → err_o=01. A subsequent legal start_i clears err_o.
- Drain timeout: ldn=3, nblk=1, only 5 tail_val_i pulses → err_o=10 exactly DRAIN_TO cycles after entering DRAIN; done_o never asserts.
- Start during a job and config stability: start_i with ldn=6 pulsed during RUN of an ldn=4 job → no effect; ldn_rg_o remains 4 throughout.
- Reset mid-RUN: assert rst_sys_n low at sample 7 of an ldn=4 job → all outputs 0 asynchronously. After release, a new ldn=4 job produces block_sync_o on its first sample.

Source files
------------

// File: rtl/r4_fft_seq_ctrl.sv
// Front-end sequencer for the radix-4 pipeline FFT chain: gates and registers the
// input sample stream, generates unit-0 syncs and tracks job completion at the tail.
module r4_fft_seq_ctrl #(
   parameter int MAN_WIDTH = 16,
   parameter int EXP_WIDTH = 6,
   parameter int LDN_MIN   = 2,
   parameter int LDN_MAX   = 11,
   parameter int DRAIN_TO  = 8192
) (
   input  logic                 clk_sys,
   input  logic                 rst_sys_n,
   input  logic                 start_i,
   input  logic [3:0]           ldn_i,
   input  logic [7:0]           nblk_i,
   input  logic                 in_val_i,
   output logic                 in_ready_o,
   input  logic [MAN_WIDTH-1:0] in_real_i,
   input  logic [MAN_WIDTH-1:0] in_imag_i,
   input  logic [EXP_WIDTH-1:0] in_exp_i,
   output logic                 block_sync_o,
   output logic                 stage_sync_o,
   output logic                 data_val_o,
   output logic [MAN_WIDTH-1:0] data_real_o,
   output logic [MAN_WIDTH-1:0] data_imag_o,
   output logic [EXP_WIDTH-1:0] data_exp_o,
   output logic [3:0]           ldn_rg_o,
   input  logic                 tail_val_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [1:0]           err_o
);

   localparam int SW = LDN_MAX;
   localparam int OW = 20;
   localparam int DW = $clog2(DRAIN_TO) + 1;
   localparam logic [3:0]    L_MIN   = 4'(LDN_MIN);
   localparam logic [3:0]    L_MAX   = 4'(LDN_MAX);
   localparam logic [DW-1:0] TO_LAST = DW'(DRAIN_TO - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t              r_state, w_state_nxt;
   logic [3:0]          r_ldn;
   logic [7:0]          r_nblk;
   logic [SW-1:0]       r_samp;
   logic [7:0]          r_blk;
   logic [OW-1:0]       r_out;
   logic [DW-1:0]       r_drain;
   logic [1:0]          r_err;
   logic                r_val, r_stage, r_block, r_done;
   logic [MAN_WIDTH-1:0] r_real, r_imag;
   logic [EXP_WIDTH-1:0] r_exp;

   logic                w_cfg_ok, w_start, w_accept;
   logic                w_samp_last, w_blk_last, w_job_last;
   logic                w_total_hit, w_to_hit, w_done_nxt, w_to_nxt;
   logic [SW:0]         w_n;
   logic [SW-1:0]       w_nm1;
   logic [OW-1:0]       w_total;

   assign w_cfg_ok    = (ldn_i >= L_MIN) && (ldn_i <= L_MAX) && (nblk_i != 8'd0);
   assign w_start     = start_i && (r_state == S_IDLE);
   assign w_accept    = in_val_i && (r_state == S_RUN);

   // N-1 from the latched ldn; for ldn = LDN_MAX the low bits of N are zero and wrap to all ones.
   assign w_n         = {{SW{1'b0}}, 1'b1} << r_ldn;
   assign w_nm1       = w_n[SW-1:0] - {{(SW-1){1'b0}}, 1'b1};
   assign w_total     = OW'(r_nblk) << r_ldn;

   assign w_samp_last = (r_samp == w_nm1);
   assign w_blk_last  = (r_blk == (r_nblk - 8'd1));
   assign w_job_last  = w_accept && w_samp_last && w_blk_last;
   assign w_total_hit = (r_out == w_total);
   assign w_to_hit    = (r_drain == TO_LAST);

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      w_to_nxt    = 1'b0;
      case (r_state)
         S_IDLE:  if (start_i && w_cfg_ok) w_state_nxt = S_RUN;
         S_RUN:   if (w_job_last) w_state_nxt = S_DRAIN;
         S_DRAIN: begin
            // Completion wins over a timeout landing on the same cycle.
            if (w_total_hit) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else if (w_to_hit) begin
               w_state_nxt = S_IDLE;
               w_to_nxt    = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_ldn   <= '0;
         r_nblk  <= '0;
         r_samp  <= '0;
         r_blk   <= '0;
         r_out   <= '0;
         r_drain <= '0;
         r_err   <= '0;
         r_val   <= 1'b0;
         r_stage <= 1'b0;
         r_block <= 1'b0;
         r_done  <= 1'b0;
         r_real  <= '0;
         r_imag  <= '0;
         r_exp   <= '0;
      end else begin
         r_val   <= w_accept;
         r_stage <= w_accept && (r_samp == '0);
         r_block <= w_accept && (r_samp == '0) && (r_blk == '0);
         r_done  <= w_done_nxt;

         if (w_accept) begin
            r_real <= in_real_i;
            r_imag <= in_imag_i;
            r_exp  <= in_exp_i;
            if (w_samp_last) begin
               r_samp <= '0;
               r_blk  <= w_blk_last ? 8'd0 : r_blk + 8'd1;
            end else begin
               r_samp <= r_samp + {{(SW-1){1'b0}}, 1'b1};
            end
         end

         // Tail pulses count from RUN onward since the pipeline may emit before input ends.
         if (r_state != S_IDLE && tail_val_i) r_out <= r_out + {{(OW-1){1'b0}}, 1'b1};

         if (r_state == S_DRAIN) r_drain <= r_drain + {{(DW-1){1'b0}}, 1'b1};
         else                    r_drain <= '0;

         if (w_start) begin
            if (w_cfg_ok) begin
               r_ldn  <= ldn_i;
               r_nblk <= nblk_i;
               r_samp <= '0;
               r_blk  <= '0;
               r_out  <= '0;
               r_err  <= 2'b00;
            end else begin
               r_err  <= 2'b01;
            end
         end

         if (w_to_nxt) r_err <= 2'b10;
      end
   end

   assign in_ready_o   = (r_state == S_RUN);
   assign busy_o       = (r_state != S_IDLE);
   assign block_sync_o = r_block;
   assign stage_sync_o = r_stage;
   assign data_val_o   = r_val;
   assign data_real_o  = r_real;
   assign data_imag_o  = r_imag;
   assign data_exp_o   = r_exp;
   assign ldn_rg_o     = r_ldn;
   assign done_o       = r_done;
   assign err_o        = r_err;

endmodule

// File: tb/tb_r4_fft_seq_ctrl.sv
// Directed bench for r4_fft_seq_ctrl: per-scenario tasks with inline expected values.
module tb_r4_fft_seq_ctrl;

   localparam int DRAIN_TO = 8192;

   logic        clk_sys, rst_sys_n;
   logic        start_i, in_val_i, tail_val_i;
   logic [3:0]  ldn_i;
   logic [7:0]  nblk_i;
   logic [15:0] in_real_i, in_imag_i;
   logic [5:0]  in_exp_i;
   logic        in_ready_o, block_sync_o, stage_sync_o, data_val_o, busy_o, done_o;
   logic [15:0] data_real_o, data_imag_o;
   logic [5:0]  data_exp_o;
   logic [3:0]  ldn_rg_o;
   logic [1:0]  err_o;

   int checks = 0;
   int errors = 0;

   r4_fft_seq_ctrl #(.MAN_WIDTH(16), .EXP_WIDTH(6), .LDN_MIN(2), .LDN_MAX(11),
                     .DRAIN_TO(DRAIN_TO)) dut (
      .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .start_i(start_i), .ldn_i(ldn_i),
      .nblk_i(nblk_i), .in_val_i(in_val_i), .in_ready_o(in_ready_o),
      .in_real_i(in_real_i), .in_imag_i(in_imag_i), .in_exp_i(in_exp_i),
      .block_sync_o(block_sync_o), .stage_sync_o(stage_sync_o), .data_val_o(data_val_o),
      .data_real_o(data_real_o), .data_imag_o(data_imag_o), .data_exp_o(data_exp_o),
      .ldn_rg_o(ldn_rg_o), .tail_val_i(tail_val_i), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o));

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic do_start(input logic [3:0] l, input logic [7:0] n);
      @(negedge clk_sys);
      start_i = 1'b1; ldn_i = l; nblk_i = n;
      @(negedge clk_sys);
      start_i = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk_sys);
      rst_sys_n = 1'b0;
      @(negedge clk_sys);
      rst_sys_n = 1'b1;
   endtask

   // Drives n tail pulses then idles a bounded window; returns how many done pulses appeared.
   task automatic drive_tail(input int n, output int dones);
      dones = 0;
      for (int t = 0; t < n + 40; t++) begin
         tail_val_i = (t < n);
         @(negedge clk_sys);
         if (done_o === 1'b1) dones++;
      end
      tail_val_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_sys_n = 1'b0;
      #12;
      checks++;
      if ({in_ready_o, block_sync_o, stage_sync_o, data_val_o, busy_o, done_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {in_ready_o, block_sync_o, stage_sync_o, data_val_o, busy_o, done_o});
      end
      checks++;
      if ({data_real_o, data_imag_o, data_exp_o, ldn_rg_o, err_o} !== 44'h0) begin
         errors++;
         $display("FAIL reset_data: got %h want 0",
                  {data_real_o, data_imag_o, data_exp_o, ldn_rg_o, err_o});
      end
      @(negedge clk_sys);
      rst_sys_n = 1'b1;
   endtask

   task automatic test_single_block();
      int d;
      do_start(4'd4, 8'd1);
      checks++;
      if (busy_o !== 1'b1 || ldn_rg_o !== 4'd4) begin
         errors++;
         $display("FAIL single_start: busy=%b ldn_rg=%0d want 1/4", busy_o, ldn_rg_o);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL single_ready[%0d]: got %b want 1", i, in_ready_o);
         end
         in_val_i = 1'b1; in_real_i = 16'(100 + i); in_imag_i = -16'(i); in_exp_i = 6'(i);
         @(negedge clk_sys);
         checks++;
         if (data_val_o !== 1'b1 || data_real_o !== 16'(100 + i) || data_imag_o !== -16'(i) ||
             data_exp_o !== 6'(i) || stage_sync_o !== (i == 0) || block_sync_o !== (i == 0)) begin
            errors++;
            $display("FAIL single_out[%0d]: val=%b re=%0d im=%h ex=%0d ss=%b bs=%b want 1/%0d/%h/%0d/%b/%b",
                     i, data_val_o, data_real_o, data_imag_o, data_exp_o, stage_sync_o,
                     block_sync_o, 100 + i, -16'(i), i, i == 0, i == 0);
         end
      end
      in_val_i = 1'b0;
      checks++;
      if (in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL single_ready_drop: got %b want 0", in_ready_o);
      end
      @(negedge clk_sys);
      checks++;
      if (data_val_o !== 1'b0 || data_real_o !== 16'd115) begin
         errors++;
         $display("FAIL single_hold: val=%b re=%0d want 0/115", data_val_o, data_real_o);
      end
      drive_tail(16, d);
      checks++;
      if (d !== 1 || busy_o !== 1'b0 || err_o !== 2'b00) begin
         errors++;
         $display("FAIL single_done: dones=%0d busy=%b err=%b want 1/0/00", d, busy_o, err_o);
      end
   endtask

   task automatic test_multi_gap();
      int k = 0;
      int pulses = 0;
      int d;
      do_start(4'd2, 8'd3);
      for (int c = 0; c < 24; c++) begin
         in_val_i = (c % 2 == 0);
         in_real_i = 16'(k);
         @(negedge clk_sys);
         if (data_val_o === 1'b1) pulses++;
         checks++;
         if (c % 2 == 0) begin
            if (data_val_o !== 1'b1 || data_real_o !== 16'(k) ||
                stage_sync_o !== (k % 4 == 0) || block_sync_o !== (k == 0)) begin
               errors++;
               $display("FAIL multi_out[%0d]: val=%b re=%0d ss=%b bs=%b want 1/%0d/%b/%b",
                        k, data_val_o, data_real_o, stage_sync_o, block_sync_o, k,
                        k % 4 == 0, k == 0);
            end
            k++;
         end else if (data_val_o !== 1'b0 || stage_sync_o !== 1'b0 || block_sync_o !== 1'b0) begin
            errors++;
            $display("FAIL multi_gap[%0d]: val=%b ss=%b bs=%b want 0/0/0",
                     c, data_val_o, stage_sync_o, block_sync_o);
         end
      end
      in_val_i = 1'b0;
      checks++;
      if (pulses !== 12 || in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL multi_count: pulses=%0d ready=%b want 12/0", pulses, in_ready_o);
      end
      drive_tail(12, d);
      checks++;
      if (d !== 1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL multi_done: dones=%0d busy=%b want 1/0", d, busy_o);
      end
   endtask

   task automatic test_illegal();
      logic [3:0] l_tab [3] = '{4'd1, 4'd12, 4'd4};
      logic [7:0] n_tab [3] = '{8'd1, 8'd1, 8'd0};
      for (int i = 0; i < 3; i++) begin
         pulse_reset();
         do_start(l_tab[i], n_tab[i]);
         @(negedge clk_sys);
         checks++;
         if (err_o !== 2'b01 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL illegal[%0d]: err=%b busy=%b want 01/0", i, err_o, busy_o);
         end
      end
      do_start(4'd3, 8'd1);
      checks++;
      if (err_o !== 2'b00 || busy_o !== 1'b1 || ldn_rg_o !== 4'd3) begin
         errors++;
         $display("FAIL illegal_clear: err=%b busy=%b ldn_rg=%0d want 00/1/3",
                  err_o, busy_o, ldn_rg_o);
      end
   endtask

   // Continues the ldn=3 job left running by test_illegal.
   task automatic test_drain_timeout();
      int early = 0;
      int dones = 0;
      for (int i = 0; i < 8; i++) begin
         in_val_i = 1'b1; in_real_i = 16'(i);
         @(negedge clk_sys);
      end
      in_val_i = 1'b0;
      checks++;
      if (in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL drain_enter: ready=%b busy=%b want 0/1", in_ready_o, busy_o);
      end
      for (int j = 1; j <= DRAIN_TO; j++) begin
         tail_val_i = (j <= 5);
         @(negedge clk_sys);
         if (done_o === 1'b1) dones++;
         if (j < DRAIN_TO) begin
            if (err_o !== 2'b00 || busy_o !== 1'b1) early++;
         end else begin
            checks++;
            if (err_o !== 2'b10 || busy_o !== 1'b0) begin
               errors++;
               $display("FAIL drain_timeout: err=%b busy=%b want 10/0", err_o, busy_o);
            end
         end
      end
      tail_val_i = 1'b0;
      checks++;
      if (early !== 0) begin
         errors++;
         $display("FAIL drain_early: early cycles=%0d want 0", early);
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL drain_no_done: dones=%0d want 0", dones);
      end
   endtask

   task automatic test_start_during_job();
      int d;
      do_start(4'd4, 8'd1);
      for (int i = 0; i < 16; i++) begin
         in_val_i = 1'b1; in_real_i = 16'(i);
         start_i = (i == 5);
         if (i == 5) begin ldn_i = 4'd6; nblk_i = 8'd2; end
         @(negedge clk_sys);
         checks++;
         if (data_val_o !== 1'b1 || data_real_o !== 16'(i) || stage_sync_o !== (i == 0) ||
             ldn_rg_o !== 4'd4 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL restart_out[%0d]: val=%b re=%0d ss=%b ldn_rg=%0d busy=%b want 1/%0d/%b/4/1",
                     i, data_val_o, data_real_o, stage_sync_o, ldn_rg_o, busy_o, i, i == 0);
         end
      end
      start_i = 1'b0; in_val_i = 1'b0;
      checks++;
      if (in_ready_o !== 1'b0 || ldn_rg_o !== 4'd4) begin
         errors++;
         $display("FAIL restart_end: ready=%b ldn_rg=%0d want 0/4", in_ready_o, ldn_rg_o);
      end
      drive_tail(16, d);
      checks++;
      if (d !== 1 || busy_o !== 1'b0 || ldn_rg_o !== 4'd4) begin
         errors++;
         $display("FAIL restart_done: dones=%0d busy=%b ldn_rg=%0d want 1/0/4", d, busy_o, ldn_rg_o);
      end
   endtask

   task automatic test_reset_mid_run();
      do_start(4'd4, 8'd1);
      for (int i = 0; i < 7; i++) begin
         in_val_i = 1'b1; in_real_i = 16'(i + 1);
         @(negedge clk_sys);
      end
      in_real_i = 16'd8;
      #2 rst_sys_n = 1'b0;
      #1;
      checks++;
      if ({in_ready_o, block_sync_o, stage_sync_o, data_val_o, busy_o, done_o} !== 6'b0 ||
          {data_real_o, data_imag_o, data_exp_o, ldn_rg_o, err_o} !== 44'h0) begin
         errors++;
         $display("FAIL midrst: ctrl=%b data=%h want 0/0",
                  {in_ready_o, block_sync_o, stage_sync_o, data_val_o, busy_o, done_o},
                  {data_real_o, data_imag_o, data_exp_o, ldn_rg_o, err_o});
      end
      in_val_i = 1'b0;
      @(negedge clk_sys);
      rst_sys_n = 1'b1;
      do_start(4'd4, 8'd1);
      in_val_i = 1'b1; in_real_i = 16'd77;
      @(negedge clk_sys);
      in_val_i = 1'b0;
      checks++;
      if (data_val_o !== 1'b1 || block_sync_o !== 1'b1 || stage_sync_o !== 1'b1 ||
          data_real_o !== 16'd77 || ldn_rg_o !== 4'd4) begin
         errors++;
         $display("FAIL midrst_restart: val=%b bs=%b ss=%b re=%0d ldn_rg=%0d want 1/1/1/77/4",
                  data_val_o, block_sync_o, stage_sync_o, data_real_o, ldn_rg_o);
      end
   endtask

   initial begin
      start_i = 1'b0; in_val_i = 1'b0; tail_val_i = 1'b0;
      ldn_i = 4'd0; nblk_i = 8'd0;
      in_real_i = '0; in_imag_i = '0; in_exp_i = '0;
      test_reset();
      test_single_block();
      test_multi_gap();
      test_illegal();
      test_drain_timeout();
      test_start_during_job();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
